// File: rtl/cam_reset_seq.sv
// -----------------------------------------------------------------------------
// cam_reset_seq
//
// Power-up reset sequencer for the OV5640 capture path. It waits for a
// stable clock-lock indication, then steps the camera power-down and reset
// pins through timed phases. It then fires a single start pulse at the SCCB
// configuration master and holds a completion flag.
//
// Parameters:
//   T_PWDN     cycles pwdn_o stays high after lock is accepted (0 acts as 1)
//   T_RST      cycles cam_rstn_o stays low after pwdn_o falls  (0 acts as 1)
//   T_SETTLE   cycles from cam_rstn_o rising to cfg_start_o    (0 acts as 1)
//   LOCK_FILT  consecutive synced-high lock cycles required (filter build only)
//
// Ports:
//   clk_i        system clock
//   rst_i        asynchronous active-high reset (deassertion must meet recovery)
//   lock_i       PLL/clock-good, asynchronous to clk_i
//   restart_i    synchronous one-cycle request to rerun the sequence
//   pwdn_o       camera power-down, active high
//   cam_rstn_o   camera reset, active low
//   cfg_start_o  one-cycle pulse to start camera configuration
//   done_o       sequence complete (level)
//   state_dg_o   current state encoding, for debug
//
// Build option:
//   CAM_RSTSEQ_LOCK_FILTER_EN  when defined, lock is accepted only after
//                              LOCK_FILT consecutive synced-high cycles.
// -----------------------------------------------------------------------------
module cam_reset_seq #(
    parameter logic [19:0] T_PWDN   = 20'd10000,
    parameter logic [19:0] T_RST    = 20'd20000,
    parameter logic [19:0] T_SETTLE = 20'd40000
`ifdef CAM_RSTSEQ_LOCK_FILTER_EN
    ,
    parameter logic [7:0]  LOCK_FILT = 8'd16
`endif
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       lock_i,
    input  logic       restart_i,
    output logic       pwdn_o,
    output logic       cam_rstn_o,
    output logic       cfg_start_o,
    output logic       done_o,
    output logic [2:0] state_dg_o
);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_PWDN      = 3'd1,
        S_RST       = 3'd2,
        S_SETTLE    = 3'd3,
        S_START     = 3'd4,
        S_DONE      = 3'd5
    } state_e;

    // Last counter value of each timed phase; a zero length behaves as one.
    localparam logic [19:0] PWDN_LAST   = (T_PWDN   == 20'd0) ? 20'd0 : T_PWDN   - 20'd1;
    localparam logic [19:0] RST_LAST    = (T_RST    == 20'd0) ? 20'd0 : T_RST    - 20'd1;
    localparam logic [19:0] SETTLE_LAST = (T_SETTLE == 20'd0) ? 20'd0 : T_SETTLE - 20'd1;

    state_e      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [1:0]  sync_q;
    logic        lk_s;
    logic        lock_ok;
    logic        abort;
    logic        pwdn_q, pwdn_d;
    logic        rstn_q, rstn_d;
    logic        start_q, start_d;
    logic        done_q, done_d;

    // NOTE: lock_i is asynchronous; only the second flop's output may feed logic.
    assign lk_s = sync_q[1];

`ifdef CAM_RSTSEQ_LOCK_FILTER_EN
    localparam logic [7:0] FILT_LAST = (LOCK_FILT == 8'd0) ? 8'd0 : LOCK_FILT - 8'd1;

    logic [7:0] filt_q, filt_d;

    // Run-length of synced-high lock while waiting; any low sample, a restart
    // or leaving WAIT_LOCK drops it back to zero.
    always_comb begin
        filt_d  = 8'd0;
        lock_ok = 1'b0;
        if (state_q == S_WAIT_LOCK && lk_s && !restart_i) begin
            if (filt_q == FILT_LAST) begin
                lock_ok = 1'b1;
            end else begin
                filt_d = filt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            filt_q <= 8'd0;
        end else begin
            filt_q <= filt_d;
        end
    end
`else
    assign lock_ok = lk_s;
`endif

    // Lock loss is only an abort once the sequence has started; restart
    // aborts from anywhere (and pins WAIT_LOCK while held).
    assign abort = restart_i || ((state_q != S_WAIT_LOCK) && !lk_s);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = 20'd0;

        case (state_q)
            S_WAIT_LOCK: if (lock_ok)                 state_d = S_PWDN;
            S_PWDN:      if (cnt_q == PWDN_LAST)      state_d = S_RST;
            S_RST:       if (cnt_q == RST_LAST)       state_d = S_SETTLE;
            S_SETTLE:    if (cnt_q == SETTLE_LAST)    state_d = S_START;
            S_START:                                  state_d = S_DONE;
            S_DONE:                                   state_d = S_DONE;
            default:                                  state_d = S_WAIT_LOCK;
        endcase

        if (abort) begin
            state_d = S_WAIT_LOCK;
        end

        // Shared phase counter: advances only while a timed phase continues,
        // so it is zero on every state entry.
        if (state_d == state_q &&
            (state_q == S_PWDN || state_q == S_RST || state_q == S_SETTLE)) begin
            cnt_d = cnt_q + 20'd1;
        end

        // Outputs decoded from the next state so they move with the transition.
        pwdn_d  = (state_d == S_WAIT_LOCK) || (state_d == S_PWDN);
        rstn_d  = !((state_d == S_WAIT_LOCK) || (state_d == S_PWDN) || (state_d == S_RST));
        start_d = (state_d == S_START);
        done_d  = (state_d == S_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= 2'b00;
            state_q <= S_WAIT_LOCK;
            cnt_q   <= 20'd0;
            pwdn_q  <= 1'b1;
            rstn_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], lock_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwdn_q  <= pwdn_d;
            rstn_q  <= rstn_d;
            start_q <= start_d;
            done_q  <= done_d;
        end
    end

    assign pwdn_o      = pwdn_q;
    assign cam_rstn_o  = rstn_q;
    assign cfg_start_o = start_q;
    assign done_o      = done_q;
    assign state_dg_o  = state_q;

endmodule
